// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-ported RAM between an instruction-fetch (IF) port and a
// load/store (MEM) port. Loads/stores normally win, but a starvation counter
// hands the RAM to fetch after STARVE_LIMIT consecutive MEM wins while fetch
// waits. Read responses come back one cycle after the grant and are steered
// to the port that owned the read.

module ram_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,

  output logic [31:0] ram_addr,
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata
);

  // A limit of zero still needs a one-bit counter that simply stays at zero.
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_MEM  = 2'd2
  } owner_e;

  owner_e           owner_q;
  owner_e           owner_d;
  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starved;
  logic             grant_if;
  logic             grant_mem;

  // Arbitration: MEM wins a tie unless fetch has been passed over too often;
  // reset_n gates both grants so they drop the instant reset asserts.
  always_comb begin
    starved   = (starve_cnt_q == CNT_MAX);
    grant_if  = reset_n && if_req && (!mem_req || starved);
    grant_mem = reset_n && mem_req && !(if_req && starved);
  end

  assign if_gnt  = grant_if;
  assign mem_gnt = grant_mem;

  // Starvation counter: counts MEM wins while fetch waits, forgets as soon as
  // fetch is served or stops asking, and saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_mem && !starved) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Counter register; reset also clears any history of passed-over fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response owner register; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWNER_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Owner next state: whoever wins a read this cycle owns next cycle's data.
  always_comb begin
    owner_d = OWNER_NONE;
    if (grant_if) begin
      owner_d = OWNER_IF;
    end else if (grant_mem && !mem_we) begin
      owner_d = OWNER_MEM;
    end
  end

  // Owner outputs: one-cycle valid pulses, data passed straight from the RAM.
  always_comb begin
    if_rvalid  = (owner_q == OWNER_IF);
    mem_rvalid = (owner_q == OWNER_MEM);
    if_rdata   = ram_rdata;
    mem_rdata  = ram_rdata;
  end

  // RAM drive: the winner's request goes out in its grant cycle, all zero when idle.
  always_comb begin
    ram_addr  = '0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_wstrb = '0;
    if (grant_if) begin
      ram_addr = if_addr;
      ram_re   = 1'b1;
    end else if (grant_mem) begin
      ram_addr = mem_addr;
      if (mem_we) begin
        ram_we    = 1'b1;
        ram_wdata = mem_wdata;
        ram_wstrb = mem_wstrb;
      end else begin
        ram_re = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed scenarios followed by random traffic. A simple word-array RAM sits
// behind the DUT; a reference model predicts grants, RAM strobes and the read
// responses from the arbitration rules and its own copy of memory contents.

module tb_ram_port_arbiter;

  localparam int STARVE_LIMIT = 3;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;

  int total;
  int bad;

  // RAM contents seen by the DUT, and the model's own idea of them.
  logic [31:0] ram_mem   [256];
  logic [31:0] model_mem [256];

  // Reference model state: times fetch has been passed over, pending response.
  int          exp_cnt;
  int          pend_owner;   // 0 none, 1 fetch, 2 load/store
  logic [31:0] pend_data;

  logic        last_if_gnt;
  logic        last_if_rvalid;
  logic [31:0] last_if_rdata;
  logic        last_mem_rvalid;
  logic [7:0]  gseq;

  ram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_wstrb (ram_wstrb),
    .ram_rdata (ram_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against what the model predicts for this cycle.
  task automatic checkCycle(input logic ireq, input logic [31:0] iaddr,
                            input logic mreq, input logic mwe, input logic [31:0] maddr,
                            input logic [31:0] mwdata, input logic [3:0] mstrb);
    logic win_if, win_mem, exp_re, exp_we;
    logic [31:0] exp_addr;
    win_if   = ireq && (!mreq || exp_cnt == STARVE_LIMIT);
    win_mem  = mreq && !win_if;
    exp_re   = win_if || (win_mem && !mwe);
    exp_we   = win_mem && mwe;
    exp_addr = win_if ? iaddr : (win_mem ? maddr : 32'h0);
    checkOutput("if_gnt",  {31'b0, if_gnt},  {31'b0, win_if});
    checkOutput("mem_gnt", {31'b0, mem_gnt}, {31'b0, win_mem});
    checkOutput("ram_re",  {31'b0, ram_re},  {31'b0, exp_re});
    checkOutput("ram_we",  {31'b0, ram_we},  {31'b0, exp_we});
    checkOutput("ram_addr", ram_addr, exp_addr);
    if (!exp_re) begin
      checkOutput("ram_wdata", ram_wdata, exp_we ? mwdata : 32'h0);
      checkOutput("ram_wstrb", {28'b0, ram_wstrb}, exp_we ? {28'b0, mstrb} : 32'h0);
    end
    checkOutput("if_rvalid",  {31'b0, if_rvalid},  (pend_owner == 1) ? 32'h1 : 32'h0);
    checkOutput("mem_rvalid", {31'b0, mem_rvalid}, (pend_owner == 2) ? 32'h1 : 32'h0);
    checkOutput("rvalid_excl", {31'b0, if_rvalid & mem_rvalid}, 32'h0);
    if (pend_owner == 1) checkOutput("if_rdata", if_rdata, pend_data);
    if (pend_owner == 2) checkOutput("mem_rdata", mem_rdata, pend_data);
    last_if_gnt     = if_gnt;
    last_if_rvalid  = if_rvalid;
    last_if_rdata   = if_rdata;
    last_mem_rvalid = mem_rvalid;
  endtask

  // Advance the reference model across the clock edge.
  task automatic modelAdvance(input logic ireq, input logic [31:0] iaddr,
                              input logic mreq, input logic mwe, input logic [31:0] maddr,
                              input logic [31:0] mwdata, input logic [3:0] mstrb);
    logic win_if, win_mem;
    win_if  = ireq && (!mreq || exp_cnt == STARVE_LIMIT);
    win_mem = mreq && !win_if;
    pend_owner = 0;
    if (win_if) begin
      pend_owner = 1;
      pend_data  = model_mem[iaddr[9:2]];
    end else if (win_mem && !mwe) begin
      pend_owner = 2;
      pend_data  = model_mem[maddr[9:2]];
    end else if (win_mem && mwe) begin
      model_mem[maddr[9:2]] = mergeBytes(model_mem[maddr[9:2]], mwdata, mstrb);
    end
    if (!ireq || win_if) exp_cnt = 0;
    else if (win_mem && exp_cnt < STARVE_LIMIT) exp_cnt++;
  endtask

  // One clock cycle: drive requests, check mid-cycle, then let the RAM respond.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic mreq, input logic mwe, input logic [31:0] maddr,
                               input logic [31:0] mwdata, input logic [3:0] mstrb);
    logic        cap_re, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    if_req    = ireq;
    if_addr   = iaddr;
    mem_req   = mreq;
    mem_we    = mwe;
    mem_addr  = maddr;
    mem_wdata = mwdata;
    mem_wstrb = mstrb;
    #4;
    checkCycle(ireq, iaddr, mreq, mwe, maddr, mwdata, mstrb);
    cap_re    = ram_re;
    cap_we    = ram_we;
    cap_addr  = ram_addr;
    cap_wdata = ram_wdata;
    cap_strb  = ram_wstrb;
    modelAdvance(ireq, iaddr, mreq, mwe, maddr, mwdata, mstrb);
    @(posedge clk);
    #1;
    if (cap_we) ram_mem[cap_addr[9:2]] = mergeBytes(ram_mem[cap_addr[9:2]], cap_wdata, cap_strb);
    if (cap_re) ram_rdata = ram_mem[cap_addr[9:2]];
    else        ram_rdata = $urandom();
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_if_gnt"},     {31'b0, if_gnt},     32'h0);
    checkOutput({phase, "_mem_gnt"},    {31'b0, mem_gnt},    32'h0);
    checkOutput({phase, "_ram_re"},     {31'b0, ram_re},     32'h0);
    checkOutput({phase, "_ram_we"},     {31'b0, ram_we},     32'h0);
    checkOutput({phase, "_if_rvalid"},  {31'b0, if_rvalid},  32'h0);
    checkOutput({phase, "_mem_rvalid"}, {31'b0, mem_rvalid}, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_cnt    = 0;
    pend_owner = 0;
    pend_data  = 32'h0;
    gseq       = 8'h0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      model_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    ram_mem[8'h40]   = 32'hDEAD_BEEF;
    model_mem[8'h40] = 32'hDEAD_BEEF;

    // Reset held with both ports requesting: nothing may be granted.
    reset_n   = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0010;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0020;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    ram_rdata = 32'h0;
    #2;
    checkResetOutputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetOutputs("reset_hold");
    reset_n = 1'b1;

    // Lone fetch of 0x100, data DEADBEEF returned the next cycle.
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("fetch_gnt", {31'b0, last_if_gnt}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("fetch_rvalid", {31'b0, last_if_rvalid}, 32'h1);
    checkOutput("fetch_rdata", last_if_rdata, 32'hDEAD_BEEF);

    // Partial store to 0x200: write strobe only, no response afterwards.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("store_no_rvalid", {31'b0, last_if_rvalid | last_mem_rvalid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);

    // Both ports loading for eight cycles: M,M,M,I,M,M,M,I.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h0000_0300 + 32'(4 * i), 1'b1, 1'b0,
                    32'h0000_0080 + 32'(4 * i), 32'h0, 4'h0);
      gseq[i] = last_if_gnt;
    end
    checkOutput("grant_seq", {24'b0, gseq}, 32'h0000_0088);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Load then fetch on consecutive cycles: responses follow one apart.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h0000_0048, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("b2b_mem_rvalid", {31'b0, last_mem_rvalid}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("b2b_if_rvalid", {31'b0, last_if_rvalid}, 32'h1);

    // Reset in the cycle after a fetch grant: the response must vanish.
    applyStimulus(1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_req = 1'b1;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    exp_cnt    = 0;
    pend_owner = 0;
    @(posedge clk);
    #1;
    checkResetOutputs("midreset_hold");
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("post_reset_gnt", {31'b0, last_if_gnt}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Random mixed traffic, requests asserted about three quarters of the time.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), $urandom() & 32'hFFFF_FFFC,
                    ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                    $urandom() & 32'hFFFF_FFFC, $urandom(), 4'($urandom_range(0, 15)));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive MEM grants while IF is waiting.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1: fetch read request.
REQ-005 SHALL have port if_addr  input  32: fetch byte address.
REQ-006 SHALL have port if_gnt  output  1: fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid  output  1: fetch read data valid.
REQ-008 SHALL have port if_rdata  output  32: fetch read data.
REQ-009 SHALL have port mem_req  input  1: load/store request.
REQ-010 SHALL have port mem_we  input  1: 1 = store, 0 = load.
REQ-011 SHALL have port mem_addr  input  32: load/store byte address.
REQ-012 SHALL have port mem_wdata  input  32: store data.
REQ-013 SHALL have port mem_wstrb  input  4: store byte enables.
REQ-014 SHALL have port mem_gnt  output  1: load/store request accepted this cycle.
REQ-015 SHALL have port mem_rvalid  output  1: load data valid.
REQ-016 SHALL have port mem_rdata  output  32: load data.
REQ-017 SHALL have port ram_addr  output  32: shared RAM address.
REQ-018 SHALL have port ram_re  output  1: RAM read strobe.
REQ-019 SHALL have port ram_we  output  1: RAM write strobe.
REQ-020 SHALL have port ram_wdata  output  32: RAM write data.
REQ-021 SHALL have port ram_wstrb  output  4: RAM byte enables.
REQ-022 SHALL have port ram_rdata  input  32: RAM read data, valid exactly one cycle after the ram_re cycle.

Function
REQ-023 SHALL grant at most one requester per cycle; if_gnt and mem_gnt are combinational from requests and state, never both 1.
REQ-024 SHALL, with only one requester active, grant it in the same cycle.
REQ-025 SHALL, with both active, grant MEM unless starve_cnt == STARVE_LIMIT, in which case grant IF.
REQ-026 SHALL keep starve_cnt (width clog2(STARVE_LIMIT+1)): +1 on each MEM grant while if_req=1 and no IF grant; cleared on any IF grant or when if_req=0; saturates at STARVE_LIMIT.
REQ-027 SHALL drive RAM from the winner in the grant cycle: IF -> ram_addr=if_addr, ram_re=1, ram_we=0; MEM load -> ram_addr=mem_addr, ram_re=1; MEM store -> ram_addr=mem_addr, ram_we=1, ram_wdata=mem_wdata, ram_wstrb=mem_wstrb.
REQ-028 SHALL, with no grant, drive ram_re=0, ram_we=0, ram_wstrb=0, ram_addr=0, ram_wdata=0.
REQ-029 SHALL register a response owner (NONE/IF/MEM) at each read grant; owner NONE for stores and idle cycles.
REQ-030 SHALL assert exactly one of if_rvalid/mem_rvalid for one cycle, the cycle after a read grant, per the registered owner.
REQ-031 SHALL pass ram_rdata to if_rdata and mem_rdata combinationally; content is qualified only by the matching rvalid.
REQ-032 SHALL produce no rvalid for stores.
REQ-033 SHALL sustain back-to-back grants every cycle: a new grant in cycle N+1 coexists with the response to the grant in cycle N.
REQ-034 SHALL tolerate requests dropped without a grant; no state change other than starve_cnt clearing per REQ-026.

Reset
REQ-035 SHALL, while reset_n=0, hold starve_cnt=0, owner=NONE, if_rvalid=0, mem_rvalid=0, and immediately (asynchronously) force if_gnt=0, mem_gnt=0, ram_re=0, ram_we=0.
REQ-036 SHALL discard a response pending when reset asserts; no rvalid in the first cycle after reset_n rises.
REQ-037 SHALL accept requests on the first rising edge after reset_n deasserts.

Verification
REQ-038 SHALL cover: if_req=1 alone, if_addr=0x100, ram_rdata=0xDEADBEEF next cycle -> if_gnt=1 in cycle 0, ram_re=1, ram_addr=0x100; if_rvalid=1, if_rdata=0xDEADBEEF in cycle 1; mem_rvalid=0.
REQ-039 SHALL cover: mem store, addr=0x200, wdata=0x12345678, wstrb=0x3 -> mem_gnt=1, ram_we=1, ram_wstrb=0x3, ram_re=0; no rvalid next cycle.
REQ-040 SHALL cover: if_req and mem_req (loads) both held high 8 cycles, STARVE_LIMIT=3 -> grant sequence M,M,M,I,M,M,M,I; matching rvalids one cycle later.
REQ-041 SHALL cover: MEM load in cycle 0, IF read in cycle 1 -> mem_rvalid in cycle 1, if_rvalid in cycle 2, never both high.
REQ-042 SHALL cover: reset_n pulled low the cycle after an IF grant -> if_rvalid stays 0; gnts and ram_re go to 0 immediately; first grant on the first edge after release.
